// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate-extension unit.
// Optional feature macro used by the top level: IMM_EXT_XFER_COUNT_EN.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        SIGN   = 2'd1,
        BRANCH = 2'd2,
        UPPER  = 2'd3
    } imm_mode_e;

    // Width of the optional output-transfer counter.
    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: zero/sign extend, branch offset
// (sign-extended, shifted left by 2) and upper placement.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic [OUT_W-1:0] result
);

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;

    assign zext = {{(OUT_W-IN_W){1'b0}}, in_imm};
    assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

    // Select the extended form for the requested mode.
    always_comb begin
        result = '0;
        case (imm_mode_e'(in_mode))
            ZERO:    result = zext;
            SIGN:    result = sext;
            BRANCH:  result = {sext[OUT_W-3:0], 2'b00};
            UPPER:   result = {in_imm, {(OUT_W-IN_W){1'b0}}};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate extension unit with valid/ready handshake on both sides.
// One output register plus a one-entry skid register; in_ready is
// registered and tracks skid emptiness.
// Optional feature macro: IMM_EXT_XFER_COUNT_EN adds a saturating
// output-transfer counter on port xfer_count.
module imm_extend_unit
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_XFER_COUNT_EN
    ,
    output logic [XFER_CNT_W-1:0] xfer_count
`endif
);

    // The branch mode shifts a sign-extended value left by two, so the
    // output must have room for the shift on top of the raw field.
    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_extend_unit: OUT_W must be >= IN_W+2");
    end

    logic [OUT_W-1:0] result;
    logic             in_xfer;
    logic             out_xfer;

    logic             skid_full;
    logic [OUT_W-1:0] skid_data;

    logic             out_valid_d;
    logic [OUT_W-1:0] out_data_d;
    logic             skid_full_d;
    logic [OUT_W-1:0] skid_data_d;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_imm  (in_imm),
        .in_mode (in_mode),
        .result  (result)
    );

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Next-state for output and skid registers.
    always_comb begin
        out_valid_d = out_valid;
        out_data_d  = out_data;
        skid_full_d = skid_full;
        skid_data_d = skid_data;
        if (skid_full) begin
            // in_ready is low while the skid holds data, so only drain here.
            if (out_xfer) begin
                out_data_d  = skid_data;
                skid_full_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (out_valid && !out_ready) begin
                skid_data_d = result;
                skid_full_d = 1'b1;
            end else begin
                out_data_d  = result;
                out_valid_d = 1'b1;
            end
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; in_ready stays low through reset and rises on the
    // first edge afterwards because it is computed from next skid state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
            in_ready  <= 1'b0;
        end else begin
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            skid_full <= skid_full_d;
            skid_data <= skid_data_d;
            in_ready  <= !skid_full_d;
        end
    end

`ifdef IMM_EXT_XFER_COUNT_EN
    // Count output transfers, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (out_xfer && (xfer_count != {XFER_CNT_W{1'b1}})) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// Scoreboard bench for imm_extend_unit: the driver pushes expected results
// on input transfer, an independent monitor pops and compares on output
// transfer and watches stall stability.
module tb_imm_extend_unit;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
`ifdef IMM_EXT_XFER_COUNT_EN
    logic [15:0]      xfer_count;
`endif

    int tests = 0;
    int fails = 0;
    logic [OUT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef IMM_EXT_XFER_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: arithmetic on the integer value of the field.
    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] imm, input logic [1:0] mode);
        longint u = longint'(imm);
        longint s = (u >= (longint'(1) << (IN_W-1))) ? u - (longint'(1) << IN_W) : u;
        longint r;
        case (mode)
            2'd0:    r = u;
            2'd1:    r = s;
            2'd2:    r = s * 4;
            default: r = u * (longint'(1) << (OUT_W-IN_W));
        endcase
        return r[OUT_W-1:0];
    endfunction

    // Monitor: sample mid-cycle; a transfer happens at the next rising edge.
    logic             prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data  = '0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid)
                check("stall_stable", 64'(out_data), 64'(prev_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 64'(out_data), 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    logic [OUT_W-1:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Present one input and hold it until accepted (bounded).
    task automatic send(input logic [IN_W-1:0] imm, input logic [1:0] mode, input logic [OUT_W-1:0] exp);
        int waitc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        #1;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        else exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waitc = 0;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        #3;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Send with out_ready=1 and an empty pipeline; check one-cycle latency.
    task automatic send_lat(input logic [IN_W-1:0] imm, input logic [1:0] mode, input logic [OUT_W-1:0] exp);
        send(imm, mode, exp);
        @(posedge clk);
        #1;
        check("lat_valid", 64'(out_valid), 64'd1);
        check("lat_data", 64'(out_data), 64'(exp));
        idle(1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 64'(in_ready), 64'd1);

        // Directed mode vectors.
        send_lat(16'hFC1F, 2'd1, 32'hFFFFFC1F);
        send_lat(16'h03E0, 2'd0, 32'h000003E0);
        send_lat(16'hFFFF, 2'd2, 32'hFFFFFFFC);
        send_lat(16'h1234, 2'd3, 32'h12340000);
        send_lat(16'h7FFF, 2'd2, 32'h0001FFFC);
        send_lat(16'h8000, 2'd1, 32'hFFFF8000);
        drain();

        // Back-to-back with the output always ready.
        for (int i = 0; i < 4; i++) begin
            logic [IN_W-1:0] v;
            v = IN_W'(16'h1111 * (i + 1));
            send(v, 2'(i), model(v, 2'(i)));
            check("b2b_in_ready", 64'(in_ready), 64'd1);
        end
        drain();

        // Stall: A to output, B to skid, C refused until drained.
        out_ready = 1'b0;
        send(16'h000A, 2'd0, 32'h0000000A);
        send(16'h800B, 2'd1, 32'hFFFF800B);
        @(negedge clk);
        in_valid = 1'b1;
        in_imm   = 16'h000C;
        in_mode  = 2'd3;
        #1;
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_out_data", 64'(out_data), 64'h0000000A);
        @(negedge clk);
        #1;
        check("stall_in_ready2", 64'(in_ready), 64'd0);
        check("stall_out_data2", 64'(out_data), 64'h0000000A);
        out_ready = 1'b1;
        send(16'h000C, 2'd3, 32'h000C0000);
        drain();

        // Reset with skid full discards everything.
        out_ready = 1'b0;
        send(16'h00AA, 2'd0, 32'h000000AA);
        send(16'h00BB, 2'd0, 32'h000000BB);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

`ifdef IMM_EXT_XFER_COUNT_EN
        for (int i = 0; i < 5; i++) send(IN_W'(i), 2'd0, OUT_W'(i));
        drain();
        check("xfer_count_5", 64'(xfer_count), 64'd5);
        @(negedge clk);
        force dut.xfer_count = 16'hFFFF;
        #1;
        release dut.xfer_count;
        send(16'h0001, 2'd0, 32'h00000001);
        drain();
        check("xfer_count_sat", 64'(xfer_count), 64'hFFFF);
`endif

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_imm    = IN_W'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) exp_q.push_back(model(in_imm, in_mode));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
